// File: rtl/crc32_pkg.sv
// crc32_pkg -- shared constants and types for the rx CRC-32 frame checker.
//   CRC32_POLY_REFL : reflected Ethernet polynomial (LSB-first bit order)
//   CRC32_INIT      : register seed at start of frame
//   CRC32_RESIDUE   : register value after a frame whose FCS is correct
//   cnt_w()         : width needed to hold a byte count of 0..nbytes
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic {ST_IDLE, ST_ACTIVE} rx_state_e;

  function automatic int cnt_w(input int nbytes);
    return $clog2(nbytes) + 1;
  endfunction

endpackage

// File: rtl/crc32_byte_lane.sv
// crc32_byte_lane -- combinational single-byte CRC-32 step (reflected,
// bits consumed LSB-first).
//   data_byte [7:0]  : byte to fold in
//   crc_in    [31:0] : running CRC before this byte
//   crc_out   [31:0] : running CRC after this byte
module crc32_byte_lane
  import crc32_pkg::*;
(
  input  logic [7:0]  data_byte,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data_byte};
    for (int b = 0; b < 8; b++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    crc_out = c;
  end

endmodule

// File: rtl/crc32_rx_check.sv
// crc32_rx_check -- multi-beat Ethernet FCS checker. Result (crc_ok,
// frame_len) is strobed by crc_valid exactly 2 cycles after the eof beat.
// Optional macro CRC_ERR_CNT_EN adds a saturating bad-frame counter.
//   rxclk, reset            : clock, async active-high reset
//   data_in                 : beat data, first byte in MSB lane
//   data_valid, sof, eof    : beat qualifier and frame delimiters
//   eof_bytes               : valid bytes on eof beat (0 = full beat)
//   crc_valid/crc_ok/frame_len : result strobe, pass flag, length incl. FCS
//   frame_abort             : sof seen while a frame was still open
//   err_cnt_clr, err_cnt    : (CRC_ERR_CNT_EN) sync clear, bad-frame count
module crc32_rx_check
  import crc32_pkg::*;
#(
  parameter  int DATA_BYTES = 8,
  parameter  int LEN_W      = 16,
  localparam int CNT_W      = cnt_w(DATA_BYTES)
) (
  input  logic                    rxclk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    sof,
  input  logic                    eof,
  input  logic [CNT_W-1:0]        eof_bytes,
`ifdef CRC_ERR_CNT_EN
  input  logic                    err_cnt_clr,
  output logic [31:0]             err_cnt,
`endif
  output logic                    crc_valid,
  output logic                    crc_ok,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    frame_abort
);

  rx_state_e              state_q, state_d;
  logic [31:0]            crc_q, crc_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   abort_q, abort_d;
  logic                   done_d;
  logic [1:0]             vld_pipe_q;
  logic [31:0]            s1_crc_q;
  logic [LEN_W-1:0]       s1_len_q;
  logic                   crc_ok_q;
  logic [LEN_W-1:0]       frame_len_q;

  // Byte-step chain: crc_after[k] is the CRC after the first k bytes of the beat.
  logic [DATA_BYTES:0][31:0] crc_after;
  logic [CNT_W-1:0]          last_bytes, beat_bytes;
  logic [31:0]               crc_beat;
  logic [LEN_W:0]            len_sum;
  logic [LEN_W-1:0]          len_next;

  // A sof beat always reseeds, so an aborting sof restarts cleanly.
  assign crc_after[0] = sof ? CRC32_INIT : crc_q;

  for (genvar k = 1; k <= DATA_BYTES; k++) begin : g_lane
    crc32_byte_lane u_lane (
      .data_byte (data_in[8*(DATA_BYTES-k+1)-1 -: 8]),
      .crc_in    (crc_after[k-1]),
      .crc_out   (crc_after[k])
    );
  end

  // 0 means a full beat; out-of-range counts are clamped to a full beat.
  always_comb begin
    last_bytes = eof_bytes;
    if (eof_bytes == '0 || eof_bytes > CNT_W'(DATA_BYTES))
      last_bytes = CNT_W'(DATA_BYTES);
  end

  assign beat_bytes = eof ? last_bytes : CNT_W'(DATA_BYTES);
  assign crc_beat   = eof ? crc_after[last_bytes] : crc_after[DATA_BYTES];
  assign len_sum    = (sof ? '0 : {1'b0, len_q}) + {{(LEN_W+1-CNT_W){1'b0}}, beat_bytes};
  assign len_next   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    abort_d = 1'b0;
    done_d  = 1'b0;
    if (data_valid && (sof || state_q == ST_ACTIVE)) begin
      abort_d = sof && (state_q == ST_ACTIVE);
      if (eof) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        crc_d   = CRC32_INIT;
        len_d   = '0;
      end else begin
        state_d = ST_ACTIVE;
        crc_d   = crc_beat;
        len_d   = len_next;
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC32_INIT;
      len_q       <= '0;
      abort_q     <= 1'b0;
      vld_pipe_q  <= '0;
      s1_crc_q    <= CRC32_INIT;
      s1_len_q    <= '0;
      crc_ok_q    <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      abort_q    <= abort_d;
      vld_pipe_q <= {vld_pipe_q[0], done_d};
      if (done_d) begin
        s1_crc_q <= crc_beat;
        s1_len_q <= len_next;
      end
      if (vld_pipe_q[0]) begin
        crc_ok_q    <= (s1_crc_q == CRC32_RESIDUE);
        frame_len_q <= s1_len_q;
      end
    end
  end

  assign crc_valid   = vld_pipe_q[1];
  assign crc_ok      = crc_ok_q;
  assign frame_len   = frame_len_q;
  assign frame_abort = abort_q;

`ifdef CRC_ERR_CNT_EN
  logic [31:0] err_cnt_q;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset)
      err_cnt_q <= '0;
    else if (err_cnt_clr)
      err_cnt_q <= '0;
    else if (crc_valid && !crc_ok && err_cnt_q != 32'hFFFFFFFF)
      err_cnt_q <= err_cnt_q + 32'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_rx_check.sv
// tb_crc32_rx_check -- randomized scoreboard bench for crc32_rx_check.
// Expected results come from a whole-frame model: crc32(payload) compared
// against the trailing 4 FCS bytes (little-endian on the wire).
module tb_crc32_rx_check;

  localparam int DB = 8;
  localparam int LW = 16;
  localparam int CW = 4;

  logic            rxclk = 1'b0;
  logic            reset;
  logic [8*DB-1:0] data_in;
  logic            data_valid, sof, eof;
  logic [CW-1:0]   eof_bytes;
  logic            crc_valid, crc_ok, frame_abort;
  logic [LW-1:0]   frame_len;
`ifdef CRC_ERR_CNT_EN
  logic            err_cnt_clr;
  logic [31:0]     err_cnt;
`endif

  crc32_rx_check #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
    .rxclk       (rxclk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .sof         (sof),
    .eof         (eof),
    .eof_bytes   (eof_bytes),
`ifdef CRC_ERR_CNT_EN
    .err_cnt_clr (err_cnt_clr),
    .err_cnt     (err_cnt),
`endif
    .crc_valid   (crc_valid),
    .crc_ok      (crc_ok),
    .frame_len   (frame_len),
    .frame_abort (frame_abort)
  );

  always #5 rxclk = ~rxclk;

  int cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  typedef struct {
    bit ok;
    int len;
    int cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         abort_q[$];
  exp_t       e_mon;
  int         a_mon;
  int         n_chk = 0;
  int         n_pass = 0;
  int         exp_errs = 0;
  bit         active = 1'b0;
  logic [7:0] frm[$];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Textbook Ethernet CRC-32 over the first n bytes of frm.
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit model_ok();
    int n = frm.size();
    logic [31:0] fcs;
    if (n < 5) return 1'b0;
    fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
    return crc_of(n - 4) == fcs;
  endfunction

  task automatic append_fcs();
    logic [31:0] c = crc_of(frm.size());
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic rand_payload(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  // Dead cycle: qualifiers must be ignored while data_valid is low.
  task automatic idle_cycle();
    data_valid = 1'b0;
    sof        = 1'($urandom);
    eof        = 1'($urandom);
    eof_bytes  = CW'($urandom);
    data_in    = {$urandom, $urandom};
    @(posedge rxclk); #1;
  endtask

  task automatic send(input bit do_eof, input int gap_at, input int gap_n,
                      input bit push_exp, input bit exp_ok, input int exp_len);
    int n  = frm.size();
    int nb = (n + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      int rem = n - b * DB;
      for (int k = 0; k < DB; k++)
        data_in[8*(DB-k)-1 -: 8] = (b*DB + k < n) ? frm[b*DB + k] : 8'($urandom);
      data_valid = 1'b1;
      sof        = (b == 0);
      eof        = do_eof && (b == nb - 1);
      eof_bytes  = (rem >= DB) ? CW'(($urandom % 2) ? DB : 0) : CW'(rem);
      if (b == 0 && active) abort_q.push_back(cyc + 1);
      if (eof) begin
        if (push_exp) begin
          exp_q.push_back('{exp_ok, exp_len, cyc + 2});
          if (!exp_ok) exp_errs++;
        end
        active = 1'b0;
      end else begin
        active = 1'b1;
      end
      @(posedge rxclk); #1;
      if (b == gap_at) repeat (gap_n) idle_cycle();
    end
  endtask

  task automatic load_check_vec();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes something.
  always @(negedge rxclk) begin
    if (reset === 1'b0) begin
      if (crc_valid) begin
        if (exp_q.size() == 0) chk("unexpected_crc_valid", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("crc_ok", crc_ok, e_mon.ok);
          chk("frame_len", frame_len, e_mon.len);
          chk("result_cycle", cyc, e_mon.cyc);
        end
      end
      if (frame_abort) begin
        if (abort_q.size() == 0) chk("unexpected_frame_abort", 1, 0);
        else begin
          a_mon = abort_q.pop_front();
          chk("abort_cycle", cyc, a_mon);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    eof_bytes = '0; data_in = '0;
`ifdef CRC_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (3) @(posedge rxclk);
    #1;
    chk("rst_crc_valid", crc_valid, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_frame_abort", frame_abort, 0);
`ifdef CRC_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    reset = 1'b0;
    @(posedge rxclk); #1;

    // Stray beats in IDLE without sof must be dropped.
    repeat (2) begin
      data_valid = 1'b1; sof = 1'b0; eof = 1'b1; eof_bytes = CW'(3);
      data_in = {$urandom, $urandom};
      @(posedge rxclk); #1;
    end
    idle_cycle();

    // Known check vector, then the same with one bit flipped in '5'.
    load_check_vec();
    send(1, -1, 0, 1, 1, 13);
    idle_cycle();
    load_check_vec();
    frm[4] ^= 8'h01;
    send(1, -1, 0, 1, 0, 13);
    repeat (3) idle_cycle();

    // 64-byte frame with a 3-cycle stall after beat 3.
    rand_payload(60); append_fcs();
    send(1, 3, 3, 1, 1, 64);
    repeat (2) idle_cycle();

    // Frame A left open, frame B aborts it.
    rand_payload(24);
    send(0, -1, 0, 0, 0, 0);
    rand_payload(30); append_fcs();
    send(1, -1, 0, 1, 1, 34);
    repeat (3) idle_cycle();

    // Back-to-back check vectors.
    load_check_vec(); send(1, -1, 0, 1, 1, 13);
    load_check_vec(); send(1, -1, 0, 1, 1, 13);
    repeat (3) idle_cycle();

    // Single-beat frame, full beat via eof_bytes=0.
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    send(1, -1, 0, 1, 0, 8);
    repeat (3) idle_cycle();

    // Same frame, then reset one cycle after the eof beat: nothing may emerge.
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    send(1, -1, 0, 0, 0, 8);
    reset = 1'b1;
    data_valid = 1'b0;
    #1;
    chk("midrst_crc_valid", crc_valid, 0);
    chk("midrst_crc_ok", crc_ok, 0);
    chk("midrst_frame_len", frame_len, 0);
    chk("midrst_frame_abort", frame_abort, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge rxclk); #1;
      chk("rst_hold_crc_valid", crc_valid, 0);
    end
`ifdef CRC_ERR_CNT_EN
    exp_errs = 0;
`endif
    reset = 1'b0;
    active = 1'b0;
    @(posedge rxclk); #1;

    // Randomized traffic.
    for (int f = 0; f < 24; f++) begin
      int  plen = $urandom_range(1, 40);
      int  gap_at = $urandom_range(0, 6);
      bit  bad = ($urandom % 4) == 0;
      rand_payload(plen); append_fcs();
      if (bad) begin
        int bi = $urandom_range(0, frm.size() - 1);
        frm[bi] ^= 8'(1 << $urandom_range(0, 7));
      end
      send(1, gap_at, $urandom_range(0, 2), 1, model_ok(), frm.size());
      repeat ($urandom_range(0, 2)) idle_cycle();
      if (($urandom % 5) == 0) begin
        data_valid = 1'b1; sof = 1'b0; eof = 1'($urandom);
        data_in = {$urandom, $urandom};
        @(posedge rxclk); #1;
      end
    end

    data_valid = 1'b0;
    repeat (6) @(posedge rxclk);
    #1;
    chk("results_pending", exp_q.size(), 0);
    chk("aborts_pending", abort_q.size(), 0);
`ifdef CRC_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_errs);
    err_cnt_clr = 1'b1;
    @(posedge rxclk); #1;
    err_cnt_clr = 1'b0;
    chk("err_cnt_clr", err_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
